// File: rtl/overture_ctrl_pkg.sv
`default_nettype none
// overture_ctrl_pkg: shared states, debug opcodes and step-count helpers for the
// Overture run controller (breakpoint build selected by OVERTURE_RUN_CTRL_BP_EN).
package overture_ctrl_pkg;

  typedef enum logic [2:0] {
    S_HALT  = 3'd0,
    S_RUN   = 3'd1,
    S_COUNT = 3'd2,
    S_RST1  = 3'd3,
    S_RST2  = 3'd4
  } run_state_e;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_HALT    = 3'd1;
  localparam logic [2:0] OP_RUN     = 3'd2;
  localparam logic [2:0] OP_STEP    = 3'd3;
  localparam logic [2:0] OP_SET_BP  = 3'd4;
  localparam logic [2:0] OP_CLR_BP  = 3'd5;
  localparam logic [2:0] OP_CPU_RST = 3'd6;
  localparam logic [2:0] OP_RSVD    = 3'd7;

  localparam logic [8:0] STEP_MAX = 9'd256;

  // A STEP argument of zero encodes the full 256-instruction burst.
  function automatic logic [8:0] step_load_value(input logic [7:0] arg);
    return (arg == 8'd0) ? STEP_MAX : {1'b0, arg};
  endfunction

endpackage
`default_nettype wire

// File: rtl/overture_run_ctrl_if.sv
`default_nettype none
// overture_run_ctrl_if: debug command handshake between host logic and the
// Overture run controller (shared by both OVERTURE_RUN_CTRL_BP_EN builds).
interface overture_run_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/overture_step_counter.sv
`default_nettype none
// overture_step_counter: 9-bit loadable down-counter with zero flag that tracks
// the remaining STEP budget (identical in both OVERTURE_RUN_CTRL_BP_EN builds).
module overture_step_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [8:0] load_val,
  input  logic       en,
  output logic [8:0] count,
  output logic       zero
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 9'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != 9'd0)) begin
      count <= count - 9'd1;
    end
  end

  assign zero = (count == 9'd0);

endmodule
`default_nettype wire

// File: rtl/overture_run_ctrl.sv
`default_nettype none
// overture_run_ctrl: halt/run/step/CPU-reset controller for overture_cpu; the
// breakpoint comparator exists only when OVERTURE_RUN_CTRL_BP_EN is defined.
module overture_run_ctrl
  import overture_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  overture_run_ctrl_if.slave        cmd,
  input  logic [7:0]                cpu_pc,
  output logic                      cpu_run,
  output logic                      cpu_reset,
  output logic                      halted,
  output logic [8:0]                steps_left,
  output logic [15:0]               retired,
  output logic                      bp_hit,
  output logic                      cmd_err
);

  localparam logic [2:0] ST_HALT  = 3'(S_HALT);
  localparam logic [2:0] ST_RUN   = 3'(S_RUN);
  localparam logic [2:0] ST_COUNT = 3'(S_COUNT);
  localparam logic [2:0] ST_RST1  = 3'(S_RST1);
  localparam logic [2:0] ST_RST2  = 3'(S_RST2);

  logic [2:0] state;
  logic [2:0] state_nx;
  logic       accept;
  logic       active;
  logic       bp_match;
  logic       bp_stop;
  logic       set_skip;
  logic       cnt_load;
  logic       cnt_en;
  logic       cnt_zero;
  logic [8:0] cnt;
  logic [8:0] cnt_load_val;

  assign cmd.cmd_ready = (state == ST_HALT) || (state == ST_RUN) || (state == ST_COUNT);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign active        = (state == ST_RUN) || (state == ST_COUNT);
  assign cpu_run       = active && !bp_match;
  assign cpu_reset     = (state == ST_RST1) || (state == ST_RST2);
  assign halted        = (state == ST_HALT);
  assign cnt_en        = (state == ST_COUNT) && cpu_run;
  assign cnt_load_val  = step_load_value(cmd.cmd_arg);
  assign steps_left    = (state == ST_COUNT) ? cnt : 9'd0;

  // Automatic stops are computed first; an accepted command that names a
  // next state then overrides them.
  always_comb begin
    state_nx = state;
    cnt_load = 1'b0;
    set_skip = 1'b0;
    bp_stop  = 1'b0;
    case (state)
      ST_HALT: state_nx = ST_HALT;
      ST_RUN: begin
        if (bp_match) begin
          state_nx = ST_HALT;
          bp_stop  = 1'b1;
        end
      end
      ST_COUNT: begin
        if (bp_match) begin
          state_nx = ST_HALT;
          bp_stop  = 1'b1;
        end else if ((cnt_en && (cnt == 9'd1)) || cnt_zero) begin
          state_nx = ST_HALT;
        end
      end
      ST_RST1: state_nx = ST_RST2;
      ST_RST2: state_nx = ST_HALT;
      default: state_nx = ST_HALT;
    endcase

    if (accept) begin
      case (cmd.cmd_op)
        OP_HALT: begin
          state_nx = ST_HALT;
          bp_stop  = 1'b0;
        end
        OP_RUN: begin
          if (state != ST_RUN) begin
            state_nx = ST_RUN;
            bp_stop  = 1'b0;
            set_skip = (state == ST_HALT);
          end
        end
        OP_STEP: begin
          if (state != ST_RUN) begin
            state_nx = ST_COUNT;
            bp_stop  = 1'b0;
            cnt_load = 1'b1;
            set_skip = 1'b1;
          end
        end
        OP_CPU_RST: begin
          state_nx = ST_RST1;
          bp_stop  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_HALT;
      retired <= 16'd0;
      cmd_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_RST2) begin
        retired <= 16'd0;
      end else if (cpu_run) begin
        retired <= retired + 16'd1;
      end
      if (accept && (cmd.cmd_op == OP_RSVD)) begin
        cmd_err <= 1'b1;
      end
    end
  end

  overture_step_counter u_step_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .count    (cnt),
    .zero     (cnt_zero)
  );

`ifdef OVERTURE_RUN_CTRL_BP_EN
  logic       bp_en;
  logic       skip;
  logic [7:0] bp_addr;

  // skip lets a resume from the breakpoint PC execute that one instruction.
  assign bp_match = bp_en && (cpu_pc == bp_addr) && !skip;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bp_en   <= 1'b0;
      bp_addr <= 8'd0;
      skip    <= 1'b0;
      bp_hit  <= 1'b0;
    end else begin
      if (accept && (cmd.cmd_op == OP_SET_BP)) begin
        bp_en   <= 1'b1;
        bp_addr <= cmd.cmd_arg;
      end else if (accept && (cmd.cmd_op == OP_CLR_BP)) begin
        bp_en <= 1'b0;
      end
      if (set_skip) begin
        skip <= 1'b1;
      end else if (cpu_run) begin
        skip <= 1'b0;
      end
      if (bp_stop) begin
        bp_hit <= 1'b1;
      end else if (accept && ((cmd.cmd_op == OP_RUN) || (cmd.cmd_op == OP_STEP))) begin
        bp_hit <= 1'b0;
      end
    end
  end
`else
  logic unused_bp;
  assign unused_bp = ^{cpu_pc, bp_stop, set_skip};
  assign bp_match  = 1'b0;
  assign bp_hit    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_overture_run_ctrl.sv
`default_nettype none
// tb_overture_run_ctrl: directed bench with a per-cycle reference model for the
// Overture run controller; follows OVERTURE_RUN_CTRL_BP_EN when defined.
module tb_overture_run_ctrl;
  import overture_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  cpu_pc = 8'd0;
  logic        cpu_run, cpu_reset, halted, bp_hit, cmd_err;
  logic [8:0]  steps_left;
  logic [15:0] retired;
  logic [30:0] dut_outs;
  logic [30:0] rst_vec;

  overture_run_ctrl_if ifc ();

  overture_run_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (ifc),
    .cpu_pc     (cpu_pc),
    .cpu_run    (cpu_run),
    .cpu_reset  (cpu_reset),
    .halted     (halted),
    .steps_left (steps_left),
    .retired    (retired),
    .bp_hit     (bp_hit),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  assign dut_outs = {ifc.cmd_ready, cpu_run, cpu_reset, halted, steps_left, retired, bp_hit, cmd_err};

  int n_cmp = 0;
  int n_bad = 0;
  int run_cycles = 0;
  int rst_cycles = 0;
  int ready_low = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Straight-line CPU: PC advances on every run cycle, zeroed by cpu_reset.
  initial forever begin
    @(posedge clk);
    if (cpu_reset) cpu_pc <= 8'd0;
    else if (cpu_run) cpu_pc <= cpu_pc + 8'd1;
  end

  // Reference model: mode 0 stopped, 1 free-running, 2 counted run, 3 CPU reset pulse.
  int         m_mode = 0;
  int         m_left = 0;
  int         m_rst_left = 0;
  bit         m_bp_on = 0;
  bit         m_skip = 0;
  bit         m_hit = 0;
  bit         m_err = 0;
  logic [7:0] m_bp = 8'd0;
  logic [15:0] m_ret = 16'd0;

  function automatic bit m_match();
    return m_bp_on && (cpu_pc == m_bp) && !m_skip;
  endfunction

  function automatic bit m_run();
    return ((m_mode == 1) || (m_mode == 2)) && !m_match();
  endfunction

  function automatic logic [30:0] m_outs();
    logic [8:0] sl;
    sl = (m_mode == 2) ? 9'(m_left) : 9'd0;
    return {m_mode != 3, m_run(), m_mode == 3, m_mode == 0, sl, m_ret, m_hit, m_err};
  endfunction

  task automatic m_reset();
    m_mode = 0; m_left = 0; m_rst_left = 0;
    m_bp_on = 0; m_skip = 0; m_hit = 0; m_err = 0;
    m_bp = 8'd0; m_ret = 16'd0;
  endtask

  task automatic m_step();
    bit run, stop, acc, own, set_skip;
    int nm;
    logic [7:0] a;
    run = m_run();
    stop = ((m_mode == 1) || (m_mode == 2)) && m_match();
    acc = ifc.cmd_valid && (m_mode != 3);
    a = ifc.cmd_arg;
    own = 0; set_skip = 0; nm = m_mode;
    if (run) begin
      m_ret++;
      if (m_mode == 2) m_left--;
    end
    if (m_mode == 3) begin
      m_rst_left--;
      if (m_rst_left == 0) begin nm = 0; m_ret = 16'd0; end
    end else if (stop || ((m_mode == 2) && (m_left == 0))) begin
      nm = 0;
    end
    if (acc) begin
      case (ifc.cmd_op)
        OP_HALT: begin nm = 0; own = 1; end
        OP_RUN: if (m_mode != 1) begin nm = 1; own = 1; set_skip = (m_mode == 0); end
        OP_STEP: if (m_mode != 1) begin
          nm = 2; own = 1; set_skip = 1;
          m_left = (a == 8'd0) ? 256 : int'(a);
        end
        OP_SET_BP: begin
`ifdef OVERTURE_RUN_CTRL_BP_EN
          m_bp_on = 1; m_bp = a;
`endif
        end
        OP_CLR_BP: begin
`ifdef OVERTURE_RUN_CTRL_BP_EN
          m_bp_on = 0;
`endif
        end
        OP_CPU_RST: begin nm = 3; own = 1; m_rst_left = 2; end
        OP_RSVD: m_err = 1;
        default: ;
      endcase
    end
    if (stop && !own) m_hit = 1;
    else if (acc && ((ifc.cmd_op == OP_RUN) || (ifc.cmd_op == OP_STEP))) m_hit = 0;
    if (set_skip) m_skip = 1;
    else if (run) m_skip = 0;
    m_mode = nm;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) m_reset();
      else m_step();
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      if (cpu_run) run_cycles++;
      if (cpu_reset) rst_cycles++;
      if (!ifc.cmd_ready) ready_low++;
      if (n_bad < 50) check("cycle_outputs", {1'b0, dut_outs}, {1'b0, m_outs()});
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] arg);
    int i;
    i = 0;
    while (!ifc.cmd_ready && (i < 20)) begin @(posedge clk); #1; i++; end
    if (!ifc.cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_ready_wait: got 0, expected 1");
    end
    ifc.cmd_valid = 1'b1; ifc.cmd_op = op; ifc.cmd_arg = arg;
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b0; ifc.cmd_op = OP_NOP; ifc.cmd_arg = 8'd0;
  endtask

  task automatic wait_halt(input int max, input string name);
    int i;
    i = 0;
    while (!halted && (i < max)) begin @(posedge clk); #1; i++; end
    check(name, 32'(halted), 32'd1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.cmd_valid = 1'b0; ifc.cmd_op = OP_NOP; ifc.cmd_arg = 8'd0;
    rst_vec = {1'b1, 1'b0, 1'b0, 1'b1, 9'd0, 16'd0, 1'b0, 1'b0};
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_values", {1'b0, dut_outs}, {1'b0, rst_vec});
    @(negedge clk); reset = 1'b1;
    cycles(1);

    // STEP 3 from reset
    run_cycles = 0;
    send(OP_STEP, 8'd3);
    check("step3_load", 32'(steps_left), 32'd3);
    wait_halt(10, "step3_halt");
    check("step3_run_cycles", 32'(run_cycles), 32'd3);
    check("step3_retired", 32'(retired), 32'd3);
    check("step3_steps_left", 32'(steps_left), 32'd0);
    check("model_retired_pin", 32'(m_ret), 32'd3);

    // CPU reset from HALT brings PC and retired back to zero
    rst_cycles = 0; ready_low = 0;
    send(OP_CPU_RST, 8'd0);
    wait_halt(10, "cpurst_halt");
    check("cpurst_pulse", 32'(rst_cycles), 32'd2);
    check("cpurst_ready_low", 32'(ready_low), 32'd2);
    check("cpurst_retired", 32'(retired), 32'd0);
    check("cpurst_pc", 32'(cpu_pc), 32'd0);

    // Breakpoint at 5 from PC 0
    send(OP_SET_BP, 8'h05);
    send(OP_RUN, 8'd0);
`ifdef OVERTURE_RUN_CTRL_BP_EN
    wait_halt(20, "bp_halt");
    check("bp_pc", 32'(cpu_pc), 32'd5);
    check("bp_retired", 32'(retired), 32'd5);
    check("bp_hit_set", 32'(bp_hit), 32'd1);
    send(OP_STEP, 8'd1);
    wait_halt(10, "bp_resume_halt");
    check("bp_resume_pc", 32'(cpu_pc), 32'd6);
    check("bp_resume_retired", 32'(retired), 32'd6);
    check("bp_hit_cleared", 32'(bp_hit), 32'd0);
`else
    cycles(20);
    check("nobp_running", 32'(halted), 32'd0);
    send(OP_HALT, 8'd0);
    check("nobp_retired", 32'(retired), 32'd21);
    check("nobp_pc", 32'(cpu_pc), 32'd21);
    check("nobp_bp_hit", 32'(bp_hit), 32'd0);
`endif
    send(OP_CLR_BP, 8'd0);

    // Reserved opcode in HALT and in RUN
    send(OP_RSVD, 8'd0);
    check("rsvd_err_halt", 32'(cmd_err), 32'd1);
    check("rsvd_stays_halt", 32'(halted), 32'd1);
    send(OP_RUN, 8'd0);
    send(OP_RSVD, 8'd0);
    check("rsvd_stays_run", 32'(cpu_run), 32'd1);

    // CPU reset during RUN
    rst_cycles = 0; ready_low = 0;
    send(OP_CPU_RST, 8'd0);
    wait_halt(10, "run_cpurst_halt");
    check("run_cpurst_pulse", 32'(rst_cycles), 32'd2);
    check("run_cpurst_ready_low", 32'(ready_low), 32'd2);
    check("run_cpurst_retired", 32'(retired), 32'd0);

    // HALT accepted in the final COUNT cycle
    send(OP_STEP, 8'd2);
    cycles(1);
    send(OP_HALT, 8'd0);
    check("lastcycle_halt", 32'(halted), 32'd1);
    check("lastcycle_retired", 32'(retired), 32'd2);
    check("model_lastcycle_pin", 32'(m_ret), 32'd2);

    // STEP 0 means 256
    run_cycles = 0;
    send(OP_STEP, 8'd0);
    check("step0_load", 32'(steps_left), 32'd256);
    wait_halt(300, "step0_halt");
    check("step0_run_cycles", 32'(run_cycles), 32'd256);
    check("step0_retired", 32'(retired), 32'd258);

    // Retired counter wrap
    send(OP_RUN, 8'd0);
    cycles(65270);
    send(OP_HALT, 8'd0);
    check("wrap_preload", 32'(retired), 32'h0000_FFF9);
    send(OP_STEP, 8'd0);
    wait_halt(300, "wrap_halt");
    check("wrap_retired", 32'(retired), 32'd249);

    // Asynchronous reset mid-RUN
    send(OP_RUN, 8'd0);
    cycles(3);
    #2;
    reset = 1'b0;
    #1;
    check("async_cpu_run", 32'(cpu_run), 32'd0);
    check("async_reset_values", {1'b0, dut_outs}, {1'b0, rst_vec});
    cycles(2);
    @(negedge clk); reset = 1'b1;
    cycles(3);
    check("post_reset_halted", 32'(halted), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/overture_run_ctrl.md
# overture_run_ctrl

Run/step controller that drives the `run` and `reset` inputs of `overture_cpu` for program wrappers and bench harnesses. Accepts debug commands over a valid/ready handshake: halt, free-run, run-N-instructions, breakpoint set/clear, CPU reset. Watches `cpu_pc` to stop on a breakpoint. Counts retired instructions. Sits between the debug/host logic and a `pgm_overture_*` wrapper.

## Interface
- No parameters. Widths fixed by the 8-bit Overture PC.
- `clk`  input  1  system clock, shared with the CPU.
- `reset`  input  1  asynchronous active-low reset for this block.
- `cmd_valid`  input  1  command present.
- `cmd_ready`  output  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_op`  input  3  opcode:
  - 0 NOP
  - 1 HALT
  - 2 RUN
  - 3 STEP
  - 4 SET_BP
  - 5 CLR_BP
  - 6 CPU_RST
  - 7 reserved
- `cmd_arg`  input  8  STEP count (0 means 256), or SET_BP address.
- `cpu_pc`  input  8  PC from the CPU.
- `cpu_run`  output  1  drives the CPU `run` input.
- `cpu_reset`  output  1  drives the CPU `reset` input (active-high).
- `halted`  output  1  controller is in HALT.
- `steps_left`  output  9  remaining STEP count. 0 outside COUNT.
- `retired`  output  16  count of cycles with `cpu_run` high. Wraps modulo 2^16.
- `bp_hit`  output  1  sticky. Last stop was caused by the breakpoint.
- `cmd_err`  output  1  sticky. A reserved opcode was accepted.

## Operation
- States: HALT, RUN, COUNT, RST1, RST2.
- Values during `reset` low:
  - State is HALT.
  - All outputs are 0, except `halted` = 1 and `cmd_ready` = 1.
  - Breakpoint is disabled. `bp_addr` = 0. `skip` = 0.
- `cmd_ready` is 1 in HALT, RUN and COUNT, and 0 in RST1 and RST2.
- HALT: holds the CPU.
  - RUN → RUN, sets `skip`.
  - STEP → COUNT with `steps_left` = `cmd_arg`, or 256 if `cmd_arg` is 0. Sets `skip`.
- RUN: HALT → HALT.
- COUNT:
  - Each cycle with `cpu_run` high decrements `steps_left`. At 1 → 0 the next state is HALT.
  - HALT → HALT. RUN → RUN.
  - A STEP reloads the count and sets `skip`.
- Common to all accepting states:
  - SET_BP sets `bp_addr` = `cmd_arg` and enables the breakpoint. CLR_BP disables it. Neither changes state.
  - CPU_RST → RST1 from any accepting state.
- RST1 → RST2 → HALT. `cpu_reset` is 1 in both RST states, so the reset pulse lasts exactly 2 cycles. `retired` clears to 0 when leaving RST2.
- Reserved opcode and NOP: no state change. The reserved opcode sets `cmd_err`.
- Breakpoint:
  - `bp_match` = breakpoint enabled && `cpu_pc` == `bp_addr` && !`skip`.
  - If `bp_match` occurs in RUN or COUNT, the next state is HALT and `bp_hit` is set.
- `cpu_run` = (state is RUN or COUNT) && !`bp_match`. The instruction at the breakpoint address is not executed.
- `skip` clears after the first cycle with `cpu_run` high. This lets a resume from a breakpoint PC execute that instruction.
- `bp_hit` clears on an accepted RUN or STEP. `cmd_err` clears only on `reset`.
- Simultaneous events:
  - A command accepted in the same cycle as a breakpoint match or the final step wins. Its next state overrides the automatic HALT.
  - A HALT command takes effect at the next edge. The current cycle's instruction still retires.

## Timing
- Command-to-effect latency: accept at edge N; `cpu_run` reflects the new state after edge N.
- For STEP k from HALT, `cpu_run` is high for exactly k consecutive cycles when no breakpoint fires.
- `cpu_run` is combinational from state, `cpu_pc` and breakpoint registers, so a breakpoint stop costs zero extra cycles.
- `cpu_pc` wraps 255 → 0 with no special handling. A breakpoint at 0 matches after the wrap.
- Asserting `reset` mid-operation forces HALT immediately and drops `cpu_run` asynchronously.

## Configuration
- `OVERTURE_RUN_CTRL_BP_EN` defined: the breakpoint comparator, `bp_addr` register, `skip` logic and `bp_hit` output are present as described.
- Not defined:
  - `bp_match` is tied to 0 and `bp_hit` reads 0.
  - SET_BP and CLR_BP are accepted as NOPs and do not set `cmd_err`.

## Structure
- Shared package `overture_ctrl_pkg` holds:
  - the state enum (HALT, RUN, COUNT, RST1, RST2);
  - opcode localparams `OP_NOP` … `OP_RSVD`;
  - the constant `STEP_MAX` = 256.
- One sub-module, `overture_step_counter`: 9-bit loadable down-counter with zero flag, enabled by `cpu_run`.
- The retired-instruction counter stays inline.

## Test plan
- Reset release, then STEP arg=3 → `cpu_run` high 3 cycles, `retired`=3, `halted`=1, `steps_left`=0.
- SET_BP 0x05, RUN from PC 0 on a straight-line program → stops with `cpu_pc`=5, `retired`=5, `bp_hit`=1. A following STEP 1 executes PC 5 and stops at PC 6.
- STEP arg=0 → 256 retired cycles, then HALT. `retired` wraps correctly when preloaded near 0xFFFF.
- CPU_RST during RUN → `cpu_reset` high exactly 2 cycles, `cmd_ready` low for those 2 cycles, then HALT with `retired`=0.
- Opcode 7 → `cmd_err`=1 and the state is unchanged. HALT issued in the last COUNT cycle → HALT with no extra retirement.
- `reset` asserted mid-RUN → `cpu_run`=0 immediately, and every output takes its reset value.
